imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time programmer for the writable instruction memory: receives a program image as a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive word-aligned instruction addresses. It holds the processor in reset while loading and releases it only after a checksum-verified image. It is the write-side counterpart of the instruction ROM's read port and uses the same addressing: byte addresses, word stride 4, `address[1:0] == 0`.

## Interface
Parameters:
- `MEM_SIZE`, default 1024: instruction memory size in bytes; a power of two. Maximum word count is `MEM_SIZE/4`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a load session; sampled only in IDLE, DONE or ERROR.
- `in_valid`  in  1  a byte is present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on any cycle with `in_valid && in_ready`.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  16  write byte address; always a multiple of 4.
- `wr_data`  out  16  instruction word to write.
- `cpu_hold`  out  1  holds the processor in reset.
- `done`  out  1  image loaded and checksum good.
- `error`  out  1  length or checksum failure.
- `word_count`  out  16  number of words written in the current session.

## Operation
- Stream format, in order:
  - length N: 2 bytes, big-endian.
  - N instruction words, each 2 bytes, high byte first.
  - 1 checksum byte: the XOR of every preceding byte in the session, including the length bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE / DONE / ERROR with `start` = 1:
  - go to LEN_HI;
  - clear the word index, `word_count`, the running XOR, `done` and `error`;
  - set `cpu_hold` = 1.
- LEN_HI: on a transfer, latch `len[15:8]` and go to LEN_LO.
- LEN_LO: on a transfer, latch `len[7:0]`, then:
  - if len > `MEM_SIZE/4`, go to ERROR;
  - else if len == 0, go to CHECK;
  - else go to DATA_HI.
- DATA_HI: on a transfer, latch the high byte and go to DATA_LO.
- DATA_LO: on a transfer, register a write:
  - `wr_data` = {hi, byte};
  - `wr_addr` = index*4;
  - `wr_en` = 1;
  - increment index and `word_count`;
  - if the new index == len, go to CHECK, else go to DATA_HI.
- CHECK: on a transfer, compare the byte to the running XOR. Equal: go to DONE. Not equal: go to ERROR.
- DONE: `done` = 1, `cpu_hold` = 0.
- ERROR: `error` = 1, `cpu_hold` stays 1, so a bad image never runs.
- `start` in any other state is ignored.
- The running XOR updates on every accepted byte except the checksum byte itself.
- Memory contents written before an error or reset are not rolled back.

## Timing
- Reset values: `in_ready`, `wr_en`, `wr_addr`, `wr_data`, `cpu_hold`, `done`, `error`, `word_count` are all 0. State is IDLE.
- `in_ready` is a combinational decode of state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 elsewhere. It does not depend on `in_valid`.
- `wr_en` goes high the cycle after the low byte is accepted, for exactly one cycle. `wr_addr`/`wr_data` are valid that cycle and hold until the next write.
- Throughput: one byte per cycle, so at most one write every 2 cycles. `in_valid` gaps stall the FSM with no side effects.
- `done`/`error` and the `cpu_hold` change register on the clock edge that accepts the checksum byte (or the length byte, for a length error). They are visible the following cycle.
- `reset` mid-session returns to IDLE next edge with all outputs at reset values, which drops `cpu_hold`. A pending `wr_en` is cancelled.
- Highest write address is `MEM_SIZE-4` (0x3FC at the default).

## Test plan
- Basic load: `start`, then bytes 00 02 12 34 AB CD 42 back-to-back. Required:
  - writes (0x0000, 0x1234) and (0x0004, 0xABCD), each a single-cycle `wr_en`;
  - `word_count` = 2, `done` = 1, `cpu_hold` 1→0, `in_ready` = 0 afterwards.
- Bad checksum: same stream with last byte 43. Required: both writes occur, `error` = 1, `done` = 0, `cpu_hold` stays 1.
- Length overflow: length bytes 01 01 (257 > 256). Required: ERROR right after LEN_LO, no `wr_en`, `in_ready` = 0 so further bytes are not consumed.
- Empty image and backpressure:
  - 00 00 00 gives `done` = 1 with zero writes.
  - Basic load with random 0–3 idle cycles between bytes gives identical writes and `done`.
- Reset mid-load: assert `reset` after the first write. Required:
  - all outputs 0 next cycle;
  - a following `start` plus the basic stream completes normally.
- Full fill: N = 256 words with value = index, correct checksum. Required: last write is (0x03FC, 0x00FF), `word_count` = 256, `done` = 1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time programmer for the writable instruction memory.
// Takes a length-prefixed, XOR-checksummed byte stream, packs 16-bit words
// and writes them to consecutive word-aligned byte addresses. The CPU is
// held in reset from session start until a checksum-verified image is in.
module imem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  // Largest legal word count; one extra bit so the compare cannot wrap.
  localparam logic [16:0] MAX_WORDS = 17'(MEM_SIZE / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q;
  logic [15:0] len_q;
  logic [7:0]  hi_q;
  logic [15:0] idx_q;
  logic [7:0]  xor_q;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        error_q;

  logic        fire;
  logic [15:0] len_d;
  logic [15:0] idx_d;
  logic [7:0]  xor_d;

  // Ready is a pure decode of the states that consume stream bytes.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: in_ready = 1'b1;
      default:                                           in_ready = 1'b0;
    endcase
  end

  assign fire  = in_valid && in_ready;
  assign len_d = {len_q[15:8], in_data};
  assign idx_d = idx_q + 16'd1;
  assign xor_d = xor_q ^ in_data;

  // Loader FSM; every output except in_ready is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q    <= S_LEN_HI;
            idx_q      <= '0;
            xor_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (fire) begin
            len_q[15:8] <= in_data;
            xor_q       <= xor_d;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (fire) begin
            len_q <= len_d;
            xor_q <= xor_d;
            if ({1'b0, len_d} > MAX_WORDS) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (fire) begin
            hi_q    <= in_data;
            xor_q   <= xor_d;
            state_q <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (fire) begin
            wr_data_q <= {hi_q, in_data};
            wr_addr_q <= {idx_q[13:0], 2'b00};
            wr_en_q   <= 1'b1;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            state_q   <= (idx_d == len_q) ? S_CHECK : S_DATA_HI;
          end
        end
        S_CHECK: begin
          if (fire) begin
            if (in_data == xor_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for the instruction memory loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        inValid;
  logic [7:0]  inData;
  logic        inReady;
  logic        wrEn;
  logic [15:0] wrAddr;
  logic [15:0] wrData;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [15:0] wordCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         writes[$];
  logic [7:0]  stream[$];
  logic        prevWrEn = 1'b0;
  int          backToBack = 0;

  imem_loader #(.MEM_SIZE(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (inValid),
    .in_data    (inData),
    .in_ready   (inReady),
    .wr_en      (wrEn),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .cpu_hold   (cpuHold),
    .done       (done),
    .error      (error),
    .word_count (wordCount)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Log every write strobe at the falling edge and flag strobes longer than a cycle.
  always @(negedge clk) begin
    if (wrEn) begin
      writes.push_back('{wrAddr, wrData});
      if (prevWrEn) backToBack++;
    end
    prevWrEn = wrEn;
  end

  task automatic clearLog();
    writes.delete();
    backToBack = 0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit accepted = 1'b0;
    inValid = 1'b1;
    inData  = b;
    for (int c = 0; c < 20 && !accepted; c++) begin
      if (inReady) accepted = 1'b1;
      @(negedge clk);
    end
    inValid = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL byteAccept: byte %02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic sendStream(input int maxIdle);
    for (int i = 0; i < stream.size(); i++) begin
      if (i != 0 && maxIdle > 0) repeat ($urandom_range(0, maxIdle)) @(negedge clk);
      sendByte(stream[i]);
    end
  endtask

  task automatic loadBasic(input logic [7:0] csum);
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    stream.push_back(csum);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inValid = 1'b0; inData = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({inReady, wrEn, cpuHold, done, error} !== 5'b0) begin errors++; $display("[TB] FAIL resetFlags: got %b expected 00000", {inReady, wrEn, cpuHold, done, error}); end
    checks++; if ({wrAddr, wrData, wordCount} !== 48'h0) begin errors++; $display("[TB] FAIL resetBuses: got %h expected 0", {wrAddr, wrData, wordCount}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clearLog();
    doStart();
    checks++; if (cpuHold !== 1'b1 || inReady !== 1'b1) begin errors++; $display("[TB] FAIL basicHoldAfterStart: hold=%b ready=%b expected 1 1", cpuHold, inReady); end
    loadBasic(8'h42);
    sendStream(0);
    #1;
    checks++; if (writes.size() != 2) begin errors++; $display("[TB] FAIL basicWriteCount: got %0d expected 2", writes.size()); end
    else begin
      checks++; if (writes[0].addr !== 16'h0000 || writes[0].data !== 16'h1234) begin errors++; $display("[TB] FAIL basicWrite0: got %h/%h expected 0000/1234", writes[0].addr, writes[0].data); end
      checks++; if (writes[1].addr !== 16'h0004 || writes[1].data !== 16'hABCD) begin errors++; $display("[TB] FAIL basicWrite1: got %h/%h expected 0004/abcd", writes[1].addr, writes[1].data); end
    end
    checks++; if (backToBack != 0) begin errors++; $display("[TB] FAIL basicStrobeWidth: got %0d long strobes expected 0", backToBack); end
    checks++; if (wordCount !== 16'd2) begin errors++; $display("[TB] FAIL basicWordCount: got %0d expected 2", wordCount); end
    checks++; if ({done, error, cpuHold, inReady} !== 4'b1000) begin errors++; $display("[TB] FAIL basicStatus: got %b expected 1000", {done, error, cpuHold, inReady}); end
  endtask

  task automatic test_bad_checksum();
    clearLog();
    doStart();
    checks++; if (done !== 1'b0 || cpuHold !== 1'b1) begin errors++; $display("[TB] FAIL restartClears: done=%b hold=%b expected 0 1", done, cpuHold); end
    loadBasic(8'h43);
    sendStream(0);
    #1;
    checks++; if (writes.size() != 2) begin errors++; $display("[TB] FAIL badCsWrites: got %0d expected 2", writes.size()); end
    checks++; if ({done, error, cpuHold, inReady} !== 4'b0110) begin errors++; $display("[TB] FAIL badCsStatus: got %b expected 0110", {done, error, cpuHold, inReady}); end
  endtask

  task automatic test_overflow();
    clearLog();
    doStart();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL startClearsError: got %b expected 0", error); end
    stream = '{8'h01, 8'h01};
    sendStream(0);
    #1;
    checks++; if ({done, error, cpuHold, inReady} !== 4'b0110) begin errors++; $display("[TB] FAIL overflowStatus: got %b expected 0110", {done, error, cpuHold, inReady}); end
    inValid = 1'b1;
    inData  = 8'h55;
    repeat (3) @(negedge clk);
    inValid = 1'b0;
    checks++; if (inReady !== 1'b0 || error !== 1'b1 || wordCount !== 16'd0) begin errors++; $display("[TB] FAIL overflowStays: ready=%b err=%b wc=%0d expected 0 1 0", inReady, error, wordCount); end
    checks++; if (writes.size() != 0) begin errors++; $display("[TB] FAIL overflowNoWrite: got %0d writes expected 0", writes.size()); end
  endtask

  task automatic test_empty();
    clearLog();
    doStart();
    stream = '{8'h00, 8'h00, 8'h00};
    sendStream(0);
    #1;
    checks++; if (writes.size() != 0 || wordCount !== 16'd0) begin errors++; $display("[TB] FAIL emptyWrites: got %0d writes wc=%0d expected 0 0", writes.size(), wordCount); end
    checks++; if ({done, error, cpuHold} !== 3'b100) begin errors++; $display("[TB] FAIL emptyStatus: got %b expected 100", {done, error, cpuHold}); end
  endtask

  task automatic test_backpressure();
    clearLog();
    doStart();
    loadBasic(8'h42);
    sendStream(3);
    #1;
    checks++; if (writes.size() != 2) begin errors++; $display("[TB] FAIL bpWriteCount: got %0d expected 2", writes.size()); end
    else begin
      checks++; if (writes[0].addr !== 16'h0000 || writes[0].data !== 16'h1234) begin errors++; $display("[TB] FAIL bpWrite0: got %h/%h expected 0000/1234", writes[0].addr, writes[0].data); end
      checks++; if (writes[1].addr !== 16'h0004 || writes[1].data !== 16'hABCD) begin errors++; $display("[TB] FAIL bpWrite1: got %h/%h expected 0004/abcd", writes[1].addr, writes[1].data); end
    end
    checks++; if (backToBack != 0) begin errors++; $display("[TB] FAIL bpStrobeWidth: got %0d long strobes expected 0", backToBack); end
    checks++; if ({done, error, cpuHold, wordCount} !== {3'b100, 16'd2}) begin errors++; $display("[TB] FAIL bpStatus: got %b wc=%0d expected 100 2", {done, error, cpuHold}, wordCount); end
  endtask

  task automatic test_reset_mid();
    clearLog();
    doStart();
    stream = '{8'h00, 8'h02, 8'h12, 8'h34};
    sendStream(0);
    checks++; if (wrEn !== 1'b1 || wrAddr !== 16'h0000 || wrData !== 16'h1234) begin errors++; $display("[TB] FAIL midFirstWrite: en=%b %h/%h expected 1 0000/1234", wrEn, wrAddr, wrData); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({inReady, wrEn, cpuHold, done, error} !== 5'b0 || {wrAddr, wrData, wordCount} !== 48'h0) begin errors++; $display("[TB] FAIL midResetOutputs: flags=%b buses=%h expected all 0", {inReady, wrEn, cpuHold, done, error}, {wrAddr, wrData, wordCount}); end
    reset = 1'b0;
    @(negedge clk);
    clearLog();
    doStart();
    loadBasic(8'h42);
    sendStream(0);
    #1;
    checks++; if (writes.size() != 2) begin errors++; $display("[TB] FAIL midReloadWrites: got %0d expected 2", writes.size()); end
    checks++; if ({done, error, cpuHold, wordCount} !== {3'b100, 16'd2}) begin errors++; $display("[TB] FAIL midReloadStatus: got %b wc=%0d expected 100 2", {done, error, cpuHold}, wordCount); end
  endtask

  task automatic test_full_fill();
    logic [7:0] x;
    bit orderOk;
    clearLog();
    doStart();
    stream = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      stream.push_back(8'h00);
      stream.push_back(8'(i));
    end
    x = 8'h00;
    foreach (stream[i]) x = x ^ stream[i];
    stream.push_back(x);
    sendStream(0);
    #1;
    checks++; if (writes.size() != 256) begin errors++; $display("[TB] FAIL fullWriteCount: got %0d expected 256", writes.size()); end
    else begin
      checks++; if (writes[255].addr !== 16'h03FC || writes[255].data !== 16'h00FF) begin errors++; $display("[TB] FAIL fullLastWrite: got %h/%h expected 03fc/00ff", writes[255].addr, writes[255].data); end
      orderOk = 1'b1;
      for (int i = 0; i < 256; i++)
        if (writes[i].addr !== 16'(i * 4) || writes[i].data !== 16'(i)) orderOk = 1'b0;
      checks++; if (!orderOk) begin errors++; $display("[TB] FAIL fullSequence: got out-of-order writes expected addr=4*i data=i"); end
    end
    checks++; if ({done, error, cpuHold, wordCount} !== {3'b100, 16'd256}) begin errors++; $display("[TB] FAIL fullStatus: got %b wc=%0d expected 100 256", {done, error, cpuHold}, wordCount); end
  endtask

  // Run each scenario in turn, then report.
  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_overflow();
    test_empty();
    test_backpressure();
    test_reset_mid();
    test_full_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
